// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the VGA timing generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam logic DEF_SYNC_POL = 1'b0;
  localparam int DEF_CNT_W    = 10;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows are half-open: [START, END)
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD counter that resets to its terminal count so the first increment lands on 0.
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      count <= LAST;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters plus registered sync/video/strobe decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             h_wrap, v_wrap;

  mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (en),
    .count  (h_cnt),
    .wrap   (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (h_wrap),
    .count  (v_cnt),
    .wrap   (v_wrap)
  );

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

  // Next position mirrors what the counters load on this edge, so decode lines up with them.
  always_comb begin
    x_nxt = h_cnt;
    y_nxt = v_cnt;
    if (h_wrap)  x_nxt = '0;
    else if (en) x_nxt = h_cnt + 1'b1;
    if (v_wrap)      y_nxt = '0;
    else if (h_wrap) y_nxt = v_cnt + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= sync_level((x_nxt >= HS_START) && (x_nxt < HS_END), SYNC_POL);
      vsync       <= sync_level((y_nxt >= VS_START) && (y_nxt < VS_END), SYNC_POL);
      video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance plus a tiny-raster instance for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;

  logic       s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [3:0] s_px, s_py;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk_in      (clk),
    .rst         (rst),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  // 15 x 8 raster, active-high syncs: hsync at x=10..12, vsync at y=5..6, visible 8x4
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) dut_small (
    .clk_in      (clk),
    .rst         (rst),
    .en          (en),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vo),
    .pixel_x     (s_px),
    .pixel_y     (s_py),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_n, hs_first, hs_last, ls_n;
    logic vo639, vo640;
    int found, fs_n, vs_n, vo_n, rises, bad_rise;
    logic prev_vs;
    int lin0, lin1, viol;
    logic e, prev_ls;

    rst = 1'b1;
    en  = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();

    chk("rst_x", pixel_x, 799);
    chk("rst_y", pixel_y, 524);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("s_rst_x", s_px, 14);
    chk("s_rst_y", s_py, 7);
    chk("s_rst_hsync", s_hs, 0);
    chk("s_rst_vsync", s_vs, 0);

    rst = 1'b1;
    en  = 1'b1;
    tick();
    chk("rel_x", pixel_x, 0);
    chk("rel_y", pixel_y, 0);
    chk("rel_frame_start", frame_start, 1);
    chk("rel_line_start", line_start, 1);
    chk("rel_video_on", video_on, 1);
    chk("rel_hsync", hsync, 1);
    chk("rel_vsync", vsync, 1);
    chk("s_rel_frame_start", s_fs, 1);

    en = 1'b0;
    tick();
    chk("hold_x", pixel_x, 0);
    chk("hold_y", pixel_y, 0);
    chk("hold_frame_start", frame_start, 0);
    chk("hold_line_start", line_start, 0);
    chk("hold_video_on", video_on, 1);

    en = 1'b1;
    tick();
    chk("resume_x", pixel_x, 1);
    chk("resume_line_start", line_start, 0);

    hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0;
    vo639 = 1'bx; vo640 = 1'bx;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (!hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(pixel_x);
        hs_last = int'(pixel_x);
      end
      if (line_start) ls_n++;
      if (pixel_x == 10'd639) vo639 = video_on;
      if (pixel_x == 10'd640) vo640 = video_on;
    end
    chk("line_hsync_cycles", hs_n, 96);
    chk("line_hsync_first_x", hs_first, 656);
    chk("line_hsync_last_x", hs_last, 751);
    chk("line_start_count", ls_n, 1);
    chk("video_on_x639", vo639, 1);
    chk("video_on_x640", vo640, 0);
    chk("line_end_x", pixel_x, 1);
    chk("line_end_y", pixel_y, 1);

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (s_fs) found = 1;
    end
    chk("s_frame_start_seen", found, 1);
    chk("s_origin_x", s_px, 0);
    chk("s_origin_y", s_py, 0);

    fs_n = 0; vs_n = 0; hs_n = 0; vo_n = 0; rises = 0; bad_rise = 0;
    prev_vs = s_vs;
    for (int i = 0; i < 240; i++) begin
      tick();
      if (s_fs) fs_n++;
      if (s_vs) vs_n++;
      if (s_hs) hs_n++;
      if (s_vo) vo_n++;
      if (s_vs && !prev_vs) begin
        rises++;
        if (s_px != 4'd0 || s_py != 4'd5) bad_rise++;
      end
      prev_vs = s_vs;
    end
    chk("s_frame_start_count", fs_n, 2);
    chk("s_vsync_cycles", vs_n, 60);
    chk("s_hsync_cycles", hs_n, 48);
    chk("s_video_on_cycles", vo_n, 64);
    chk("s_vsync_rises", rises, 2);
    chk("s_vsync_rise_pos", bad_rise, 0);
    chk("s_frame_end_fs", s_fs, 1);

    repeat (119) tick();
    chk("s_corner_x", s_px, 14);
    chk("s_corner_y", s_py, 7);
    tick();
    chk("s_wrap_x", s_px, 0);
    chk("s_wrap_y", s_py, 0);
    chk("s_wrap_frame_start", s_fs, 1);
    chk("s_wrap_vsync", s_vs, 0);
    chk("s_wrap_hsync", s_hs, 0);

    lin0 = int'(pixel_y) * 800 + int'(pixel_x);
    viol = 0;
    prev_ls = line_start;
    for (int i = 0; i < 2000; i++) begin
      e  = (i % 2 == 0);
      en = e;
      tick();
      if (!e && (line_start || frame_start)) viol++;
      if (line_start && prev_ls) viol++;
      prev_ls = line_start;
    end
    lin1 = int'(pixel_y) * 800 + int'(pixel_x);
    chk("toggle_advance", lin1, (lin0 + 1000) % 420000);
    chk("toggle_strobe_viol", viol, 0);

    en = 1'b1;
    repeat (5) tick();
    #3 rst = 1'b0;
    #1;
    chk("async_x", pixel_x, 799);
    chk("async_y", pixel_y, 524);
    chk("async_video_on", video_on, 0);
    chk("async_hsync", hsync, 1);
    chk("async_line_start", line_start, 0);
    repeat (2) tick();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    chk("restart_x", pixel_x, 0);
    chk("restart_y", pixel_y, 0);
    chk("restart_frame_start", frame_start, 1);
    chk("restart_line_start", line_start, 1);
    chk("restart_video_on", video_on, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
